// File: rtl/rs_age_select.sv
// Oldest-first select for one reservation-station issue port.
// An age matrix orders the valid entries; the registered grant is held under back-pressure.
module rs_age_select #(
  parameter  int RS_ENTRIES = 8,
  localparam int IDX_W      = $clog2(RS_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_en,
  input  logic [IDX_W-1:0]      alloc_index,
  input  logic [RS_ENTRIES-1:0] request_vector,
  input  logic                  issue_stall,
  input  logic                  flush,
  output logic                  grant_en,
  output logic [IDX_W-1:0]      grant_index,
  output logic [RS_ENTRIES-1:0] valid_vector
);

  logic [RS_ENTRIES-1:0]                 valid_q;
  // older_q[i][j] = 1 means entry i is older than entry j.
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q;

  logic                  consume;
  logic [RS_ENTRIES-1:0] grant_oh;
  logic [RS_ENTRIES-1:0] alloc_oh;
  logic [RS_ENTRIES-1:0] dealloc;
  logic [RS_ENTRIES-1:0] cand;
  logic [RS_ENTRIES-1:0] win;
  logic [IDX_W-1:0]      winner_idx;
  logic                  any_cand;

  assign consume = grant_en & ~issue_stall;

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    grant_oh              = '0;
    grant_oh[grant_index] = 1'b1;
    alloc_oh              = '0;
    alloc_oh[alloc_index] = alloc_en;
    dealloc               = consume ? grant_oh : '0;
    // The pending (or just-consumed) entry is never a candidate.
    cand                  = request_vector & valid_q & ~(grant_en ? grant_oh : '0);
    any_cand              = |cand;
    win                   = '0;
    winner_idx            = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      win[i] = cand[i];
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if (cand[j] && older_q[j][i]) win[i] = 1'b0;
      end
    end
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (win[i]) winner_idx = IDX_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the age matrix is a flop array, not RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      older_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      older_q <= '0;
    end else begin
      valid_q <= (valid_q & ~dealloc) | alloc_oh;
      if (alloc_en) begin
        // New entry becomes the youngest: its row clears, its column records who survives this edge.
        for (int j = 0; j < RS_ENTRIES; j++) begin
          older_q[alloc_index][j] <= 1'b0;
          older_q[j][alloc_index] <= (j != int'(alloc_index)) & valid_q[j] & ~dealloc[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_en    <= 1'b0;
      grant_index <= '0;
    end else if (flush) begin
      grant_en    <= 1'b0;
    end else if (!(grant_en && issue_stall)) begin
      grant_en <= any_cand;
      if (any_cand) grant_index <= winner_idx;
    end
  end

  assign valid_vector = valid_q;

  // Dispatch must not overwrite a live entry unless that entry issues this same cycle.
  a_alloc_free_slot : assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_en && !flush) |-> (!valid_q[alloc_index] || (consume && grant_index == alloc_index)));

endmodule

// File: tb/tb_rs_age_select.sv
// Scoreboard bench for rs_age_select: expected grant indices are queued as
// stimulus is driven and popped as the DUT presents each grant.
module tb_rs_age_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_en;
  logic [2:0] alloc_index;
  logic [7:0] request_vector;
  logic       issue_stall;
  logic       flush;
  logic       grant_en;
  logic [2:0] grant_index;
  logic [7:0] valid_vector;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [2:0] sb[$];

  rs_age_select #(.RS_ENTRIES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_en       (alloc_en),
    .alloc_index    (alloc_index),
    .request_vector (request_vector),
    .issue_stall    (issue_stall),
    .flush          (flush),
    .grant_en       (grant_en),
    .grant_index    (grant_index),
    .valid_vector   (valid_vector)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_en       = 1'b0;
    alloc_index    = '0;
    request_vector = '0;
    issue_stall    = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic alloc_slot(input logic [2:0] k);
    alloc_en    = 1'b1;
    alloc_index = k;
    step();
    alloc_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      alloc_en       = 1'($urandom);
      alloc_index    = 3'($urandom);
      request_vector = 8'($urandom);
      issue_stall    = 1'($urandom);
      flush          = 1'($urandom);
      step();
      vectors++;
      if (grant_en !== 1'b0 || grant_index !== 3'd0 || valid_vector !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold: got en=%b idx=%0d valid=%h, want en=0 idx=0 valid=00",
                 grant_en, grant_index, valid_vector);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
    vectors++;
    if (grant_en !== 1'b0 || grant_index !== 3'd0 || valid_vector !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release: got en=%b idx=%0d valid=%h, want en=0 idx=0 valid=00",
               grant_en, grant_index, valid_vector);
    end
  endtask

  task automatic expect_grant(input string name);
    logic [2:0] exp_idx;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_sb_empty: got en=%b idx=%0d, scoreboard had no entry", name, grant_en, grant_index);
    end else begin
      exp_idx = sb.pop_front();
      if (grant_en !== 1'b1 || grant_index !== exp_idx) begin
        miscompares++;
        $display("FAIL %s_grant: got en=%b idx=%0d, want en=1 idx=%0d", name, grant_en, grant_index, exp_idx);
      end
    end
  endtask

  task automatic expect_idle(input string name, input logic [7:0] exp_valid);
    vectors++;
    if (grant_en !== 1'b0 || valid_vector !== exp_valid) begin
      miscompares++;
      $display("FAIL %s_idle: got en=%b valid=%h, want en=0 valid=%h", name, grant_en, valid_vector, exp_valid);
    end
  endtask

  task automatic test_age_order();
    alloc_slot(3'd5);
    alloc_slot(3'd2);
    alloc_slot(3'd7);
    vectors++;
    if (valid_vector !== 8'hA4) begin
      miscompares++;
      $display("FAIL age_valid: got valid=%h, want a4", valid_vector);
    end
    request_vector = 8'hA4;
    sb.push_back(3'd5);
    sb.push_back(3'd2);
    sb.push_back(3'd7);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_grant("age_order");
    end
    step();
    expect_idle("age_drain", 8'h00);
    request_vector = '0;
  endtask

  task automatic test_stall_hold();
    alloc_slot(3'd3);
    request_vector = 8'h08;
    sb.push_back(3'd3);
    step();
    vectors++;
    if (grant_en !== 1'b1 || grant_index !== 3'd3) begin
      miscompares++;
      $display("FAIL stall_first: got en=%b idx=%0d, want en=1 idx=3", grant_en, grant_index);
    end
    issue_stall    = 1'b1;
    request_vector = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (grant_en !== 1'b1 || grant_index !== 3'd3) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got en=%b idx=%0d, want en=1 idx=3", c, grant_en, grant_index);
      end
    end
    // The held grant is consumed in the first unstalled cycle.
    expect_grant("stall_consume");
    issue_stall = 1'b0;
    step();
    expect_idle("stall_dealloc", 8'h00);
  endtask

  task automatic test_slot_reuse();
    alloc_slot(3'd1);
    alloc_slot(3'd4);
    request_vector = 8'h02;
    sb.push_back(3'd1);
    step();
    expect_grant("reuse_first");
    request_vector = 8'h00;
    step();
    expect_idle("reuse_consumed", 8'h10);
    alloc_slot(3'd1);
    request_vector = 8'h12;
    sb.push_back(3'd4);
    sb.push_back(3'd1);
    step();
    expect_grant("reuse_order");
    step();
    expect_grant("reuse_order");
    request_vector = 8'h00;
    step();
    expect_idle("reuse_drain", 8'h00);
  endtask

  task automatic test_flush();
    alloc_slot(3'd6);
    request_vector = 8'h40;
    sb.push_back(3'd6);
    step();
    expect_grant("flush_pre");
    alloc_en    = 1'b1;
    alloc_index = 3'd0;
    flush       = 1'b1;
    step();
    idle_inputs();
    expect_idle("flush_clear", 8'h00);
    request_vector = 8'h41;
    step();
    expect_idle("flush_after", 8'h00);
    request_vector = 8'h00;
  endtask

  task automatic test_invalid_request();
    alloc_slot(3'd2);
    request_vector = 8'hFF;
    sb.push_back(3'd2);
    step();
    expect_grant("invalid_req");
    step();
    expect_idle("invalid_req_next", 8'h00);
    request_vector = 8'h00;
  endtask

  task automatic test_back_to_back_alloc_on_consume();
    // Allocating into the slot that issues this cycle is legal; it returns as the youngest.
    alloc_slot(3'd0);
    alloc_slot(3'd3);
    request_vector = 8'h01;
    sb.push_back(3'd0);
    step();
    expect_grant("b2b_first");
    alloc_en       = 1'b1;
    alloc_index    = 3'd0;
    request_vector = 8'h09;
    sb.push_back(3'd3);
    sb.push_back(3'd0);
    step();
    alloc_en = 1'b0;
    expect_grant("b2b_order");
    vectors++;
    if (valid_vector !== 8'h09) begin
      miscompares++;
      $display("FAIL b2b_valid: got valid=%h, want 09", valid_vector);
    end
    step();
    expect_grant("b2b_order");
    request_vector = 8'h00;
    step();
    expect_idle("b2b_drain", 8'h00);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_age_order();
    test_stall_hold();
    test_slot_reuse();
    test_flush();
    sb.delete();
    test_invalid_request();
    test_back_to_back_alloc_on_consume();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending grants, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_age_select.md
# rs_age_select

Oldest-first select arbiter for one reservation-station issue port. It tracks RS entry occupancy and relative age in an age matrix. Each cycle it picks the oldest entry whose wakeup request is asserted and drives a registered grant (index + enable) to the Wakeup side. The grant is held under downstream back-pressure, and the issued entry is deallocated when the grant is consumed.

## Interface
- RS_ENTRIES, 8: number of RS entries; power of two, ≥2.
- IDX_W, $clog2(RS_ENTRIES): entry index width (derived, not overridden).

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_en  in  1  Dispatch writes a new entry this cycle.
- alloc_index  in  IDX_W  slot being written.
- request_vector  in  RS_ENTRIES  per-entry ready-to-issue requests from Wakeup.
- issue_stall  in  1  functional unit cannot accept an issue this cycle.
- flush  in  1  pipeline flush; discards all entries and any pending grant.
- grant_en  out  1  registered: grant_index is a valid issue.
- grant_index  out  IDX_W  registered: entry selected for issue.
- valid_vector  out  RS_ENTRIES  registered occupancy, for Dispatch free-slot search.

## Operation
- State:
  - valid[RS_ENTRIES].
  - age matrix older[i][j], RS_ENTRIES×RS_ENTRIES; 1 means entry i is older than entry j. Diagonal unused and kept 0.
  - grant_en / grant_index registers.
- consume = grant_en & ~issue_stall.
- Allocate (alloc_en, slot k), at the clock edge:
  - valid[k] <= 1.
  - older[k][*] <= 0.
  - older[j][k] <= valid[j] for every j≠k that is not being deallocated this cycle.
  - The new entry is therefore the youngest.
- Deallocate: on consume, valid[grant_index] <= 0. The stale row and column are ignored because valid gates all use.
- Candidates, combinational: cand = request_vector & valid, with bit grant_index also cleared when grant_en=1. The pending or just-consumed entry is never re-selected.
- Winner: entry i where cand[i]=1 and no j with cand[j]=1 and older[j][i]=1. Exactly one winner exists whenever cand≠0.
- Grant register update, priority order:
  1. flush → grant_en <= 0.
  2. grant_en & issue_stall → hold grant_en and grant_index unchanged.
  3. otherwise → grant_en <= |cand; grant_index <= winner if |cand, else hold.
- Once granted, the grant stays asserted until consumed or flushed, even if request_vector drops the bit.
- Flush: valid <= 0, older <= 0, grant_en <= 0. Flush overrides a same-cycle alloc_en and consume.
- alloc_en to a slot that is valid and not being consumed in the same cycle is illegal (assertion in sim). Alloc to the slot being consumed that cycle is legal: the alloc wins, and the slot ends valid and youngest.
- Request bits for invalid entries are ignored.

## Timing
- Reset values: grant_en=0, grant_index=0, valid_vector=0, age matrix all 0.
- Select latency:
  - A request present in cycle N produces grant_en in cycle N+1.
  - An entry allocated in cycle N is valid in N+1, so it can be granted at N+2 at the earliest.
- Throughput: one grant per cycle while unstalled. The back-to-back next grant is computed in the consume cycle, excluding the consumed index.
- Back-pressure: while issue_stall=1 with grant_en=1, grant_index is stable every cycle. Consume happens on the first cycle issue_stall=0.
- issue_stall has no effect when grant_en=0; a new selection proceeds.
- Reset asserted mid-operation clears all state immediately (asynchronous); the first grant is possible 2 cycles after release plus allocation.
- Grant outputs come straight from flops; no combinational path from any input to any output.

## Test plan
- Reset: hold rst_n=0 with random inputs → grant_en=0, grant_index=0, valid_vector=0; all stay 0 one cycle after release with no alloc.
- Age order: alloc slots 5, 2, 7 in consecutive cycles, then request_vector=8'hA4 held, issue_stall=0 → grants 5, 2, 7 in consecutive cycles, then grant_en=0; valid_vector returns to 0.
- Stall hold: slot 3 granted, issue_stall=1 for 3 cycles and request bit 3 dropped → grant_index=3 and grant_en=1 stable for all 3 cycles; consumed on release, valid_vector[3]=0 next cycle.
- Slot reuse: alloc 1, 4; consume 1; alloc 1 again; request both → grant 4 before 1.
- Flush: grant_en=1 on slot 6 with alloc_en on slot 0 and flush=1 in the same cycle → next cycle grant_en=0, valid_vector=0.
- Invalid request: request_vector=8'hFF with only slot 2 valid → only index 2 granted; grant_en=0 on the following cycle.
